// File: rtl/pipe_skid_stage.sv
// ============================================================================
// pipe_skid_stage
// ----------------------------------------------------------------------------
// Single-entry pipeline register with an optional skid register. It decouples
// an upstream valid/ready producer from a downstream valid/ready consumer.
// Entries are presented one cycle after acceptance, order is preserved, and
// one entry per cycle is sustained while the consumer keeps out_ready high.
//
// Build option:
//   PIPE_SKID_STAGE_SKID_EN defined:
//       A skid register and a SKID state are present. in_ready is a register
//       output, so out_ready never reaches in_ready combinationally.
//   PIPE_SKID_STAGE_SKID_EN undefined (default):
//       There is no skid register and only EMPTY and FULL exist.
//       in_ready = !out_valid || out_ready (combinational).
//
// Parameters:
//   DATA_W  payload width (load data, ALU result, FP result, rd address)
//   CTRL_W  control-field width (wb_sel, fp_en, int_en)
//
// Ports:
//   clk        in   clock; all state changes on its rising edge
//   rst        in   asynchronous active-high reset; empties the stage
//   flush      in   synchronous kill of all held entries
//   in_valid   in   upstream entry present
//   in_ready   out  stage can accept an entry this cycle
//   in_data    in   upstream payload        [DATA_W]
//   in_ctrl    in   upstream control bits   [CTRL_W]
//   out_valid  out  downstream entry present
//   out_ready  in   downstream accepts
//   out_data   out  held payload            [DATA_W]
//   out_ctrl   out  held control bits, all zeros while out_valid is low
// ============================================================================
module pipe_skid_stage #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

`ifdef PIPE_SKID_STAGE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b01,
        ST_SKID  = 2'b10
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;
`endif

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    // The main control register is cleared whenever the stage goes empty.
    // It drives out_ctrl directly, so out_ctrl is zero while out_valid is low
    // and no output gating logic is needed.
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic                out_valid_q, out_valid_d;
    logic                in_fire_s;
    logic                out_fire_s;

`ifdef PIPE_SKID_STAGE_SKID_EN
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic                in_ready_q, in_ready_d;

    // Registered ready: high unless both registers are occupied.
    assign in_ready = in_ready_q;
`else
    logic                in_ready_s;

    // Without a skid slot, an entry can only be taken if the main register is
    // empty or is being drained in the same cycle.
    assign in_ready_s = !out_valid_q || out_ready;
    assign in_ready   = in_ready_s;
`endif

    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = main_data_q;
    assign out_ctrl  = main_ctrl_q;

`ifdef PIPE_SKID_STAGE_SKID_EN
    // Next-state and datapath selection for the three-state skid buffer.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            // Flush wins over any transfer on either side this cycle.
            state_d     = ST_EMPTY;
            main_ctrl_d = {CTRL_W{1'b0}};
            skid_data_d = {DATA_W{1'b0}};
            skid_ctrl_d = {CTRL_W{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d     = ST_FULL;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (in_fire_s && !out_fire_s) begin
                        // Consumer stalled: park the new entry behind main.
                        state_d     = ST_SKID;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (!in_fire_s && out_fire_s) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = {CTRL_W{1'b0}};
                    end else if (in_fire_s && out_fire_s) begin
                        state_d     = ST_FULL;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else begin
                        state_d     = ST_FULL;
                    end
                end
                ST_SKID: begin
                    // in_ready is low here, so only the output side can move.
                    if (out_fire_s) begin
                        state_d     = ST_FULL;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_data_d = {DATA_W{1'b0}};
                        skid_ctrl_d = {CTRL_W{1'b0}};
                    end else begin
                        state_d     = ST_SKID;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = {CTRL_W{1'b0}};
                    skid_data_d = {DATA_W{1'b0}};
                    skid_ctrl_d = {CTRL_W{1'b0}};
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID);
    end

    // Skid register and registered ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data_q <= {DATA_W{1'b0}};
            skid_ctrl_q <= {CTRL_W{1'b0}};
            in_ready_q  <= 1'b1;
        end else begin
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end
`else
    // Next-state and datapath selection for the two-state pipeline register.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            main_ctrl_d = {CTRL_W{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        state_d     = ST_FULL;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else begin
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // An input transfer while full implies the output side
                    // drains in the same cycle (see in_ready_s).
                    if (in_fire_s) begin
                        state_d     = ST_FULL;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (out_fire_s) begin
                        state_d     = ST_EMPTY;
                        main_ctrl_d = {CTRL_W{1'b0}};
                    end else begin
                        state_d     = ST_FULL;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    main_ctrl_d = {CTRL_W{1'b0}};
                end
            endcase
        end

        out_valid_d = (state_d != ST_EMPTY);
    end
`endif

    // State register, main payload register and output valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_data_q <= {DATA_W{1'b0}};
            main_ctrl_q <= {CTRL_W{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 101, meaning payload width (load data, ALU result, FP result, rd address).
REQ-002 SHALL provide parameter CTRL_W, default 3, meaning control-field width (wb_sel, fp_en, int_en).
REQ-003 SHALL provide port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset: asynchronous, active-high.
REQ-005 SHALL provide port flush  input  1  synchronous kill of all held entries.
REQ-006 SHALL provide port in_valid  input  1  upstream entry present.
REQ-007 SHALL provide port in_ready  output  1  stage can accept an entry this cycle.
REQ-008 SHALL provide port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL provide port in_ctrl  input  CTRL_W  upstream control bits.
REQ-010 SHALL provide port out_valid  output  1  downstream entry present.
REQ-011 SHALL provide port out_ready  input  1  downstream accepts.
REQ-012 SHALL provide port out_data  output  DATA_W  held payload.
REQ-013 SHALL provide port out_ctrl  output  CTRL_W  held control bits, gated by out_valid.

Function
REQ-014 SHALL transfer on the input side when in_valid && in_ready, and on the output side when out_valid && out_ready.
REQ-015 SHALL present an accepted entry on out_* exactly 1 cycle after acceptance when the stage was empty or drained that cycle.
REQ-016 SHALL sustain 1 entry per cycle when out_ready stays high.
REQ-017 SHALL preserve entry order; no entry is ever dropped or duplicated.
REQ-018 SHALL use states EMPTY (no entry), FULL (main register holds an entry), SKID (main and skid registers both hold entries).
REQ-019 EMPTY: input transfer -> FULL; otherwise stay.
REQ-020 FULL: input without output -> SKID (entry captured into skid); output without input -> EMPTY; both -> FULL with the new entry in main; neither -> stay.
REQ-021 SKID: output transfer -> FULL (skid moves to main); in_ready SHALL be 0, so no input is accepted.
REQ-022 SHALL drive in_ready = 1 in EMPTY and FULL and 0 in SKID, registered; it SHALL NOT depend combinationally on out_ready.
REQ-023 SHALL hold out_data and out_ctrl stable while out_valid && !out_ready.
REQ-024 SHALL force out_ctrl to all zeros whenever out_valid = 0; out_data is don't-care but holds its last value.
REQ-025 flush SHALL move the stage to EMPTY at the next edge, overriding any simultaneous input or output transfer; an entry offered in the flush cycle is discarded.
REQ-026 SHALL drive in_ready = 1 in the cycle after flush.

Reset
REQ-027 rst SHALL force EMPTY immediately, without waiting for clk: out_valid = 0, out_ctrl = 0, out_data = 0, skid contents = 0, in_ready = 1.
REQ-028 Reset asserted mid-transfer SHALL discard all held entries; the first edge after deassertion SHALL behave as EMPTY.

Configuration
REQ-029 Macro PIPE_SKID_STAGE_SKID_EN defined: the skid register and SKID state are present, and REQ-018 to REQ-022 apply.
REQ-030 Macro PIPE_SKID_STAGE_SKID_EN undefined: there is no skid register and only EMPTY and FULL exist; in_ready SHALL be combinational !out_valid || out_ready. Latency, ordering, flush and reset rules are unchanged.

Verification
REQ-031 Reset, then in_valid = 1, in_data = 0x1_2345_6789..., in_ctrl = 3'b101, out_ready = 1 -> out_valid = 1 and out_ctrl = 3'b101 next cycle, and the data matches.
REQ-032 Stream of 8 entries, values 1..8, with out_ready held high -> 8 consecutive output cycles carrying 1..8 in order.
REQ-033 Drop out_ready while sending A, B -> state SKID, in_ready = 0, out shows A stable; raise out_ready -> A, then B, then in_ready = 1.
REQ-034 flush asserted in SKID with in_valid = 1 -> next cycle out_valid = 0, out_ctrl = 0, in_ready = 1, and the offered entry never appears.
REQ-035 Assert rst asynchronously between edges while in FULL -> out_valid and out_ctrl are 0 before the next edge.
REQ-036 Random in_valid/out_ready at 50% density for 10k cycles, in both macro configurations -> a scoreboard shows no loss, duplication or reorder, and out_ctrl = 0 whenever out_valid = 0.
